icache: RTL and testbench

Direct-mapped instruction cache between `ifetch` and `mem_ctrl` inside the RISCV32I core. It accepts one fetch request at a time from `ifetch` and returns the 32-bit instruction in 1 cycle on a hit. On a miss it issues a word read to `mem_ctrl`, which assembles the 4 bytes, then fills the line and returns the instruction. It honours jump cancellation and the global `rdy_in` pause.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_array.sv | 50 +++++
 rtl/icache.sv | 126 ++++++++++++
 tb/tb_icache.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_pkg : shared geometry, FSM encodings and I/O-region predicate |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package icache_pkg;

    localparam int ICACHE_LINES = 64;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_LINES);
    localparam int ICACHE_TAG_W = 16 - ICACHE_IDX_W;

    localparam logic [1:0] IC_IDLE  = 2'd0;
    localparam logic [1:0] IC_MISS  = 2'd1;
    localparam logic [1:0] IC_DRAIN = 2'd2;

    // Top quarter of the 18-bit physical space is memory-mapped I/O.
    function automatic logic is_io_addr(input logic [17:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_array : valid/tag/data line storage, async-read, sync-write   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = ICACHE_LINES,
    parameter int IDX_W = ICACHE_IDX_W,
    parameter int TAG_W = ICACHE_TAG_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is qualified by the valid bit.
    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache   : direct-mapped one-word-line instruction cache             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module icache
    import icache_pkg::*;
#(
    parameter int LINES  = ICACHE_LINES,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              cancel,
    output logic              resp_valid,
    output logic [31:0]       resp_inst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 16 - IDX_W;

    logic [1:0]        r_state;
    logic [17:0]       r_fill_addr;
    logic              r_resp_valid;
    logic [31:0]       r_resp_inst;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_line_valid;
    logic [TAG_W-1:0]  w_line_tag;
    logic [31:0]       w_line_data;
    logic              w_hit;
    logic              w_accept;
    logic              w_fill_evt;
    logic              w_wr_en;
    logic              w_unused;

    assign w_unused   = ^req_addr[1:0];
    assign req_ready  = rst_in && rdy_in && (r_state == IC_IDLE);
    assign w_accept   = req_valid && req_ready && !cancel;
    assign w_hit      = w_line_valid && (w_line_tag == req_addr[17:2+IDX_W])
                        && !is_io_addr(req_addr[17:0]);
    assign w_fill_evt = rdy_in && mem_resp_valid
                        && ((r_state == IC_MISS) || (r_state == IC_DRAIN));
    assign w_wr_en    = w_fill_evt && !is_io_addr(r_fill_addr);

    icache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_rd_idx   (req_addr[2+:IDX_W]),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_fill_addr[2+:IDX_W]),
        .i_wr_tag   (r_fill_addr[17:2+IDX_W]),
        .i_wr_data  (mem_resp_data)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IC_IDLE;
            r_fill_addr  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_inst  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
        end else if (rdy_in) begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IC_IDLE: begin
                    if (w_accept) begin
                        r_fill_addr <= req_addr[17:0];
                        if (w_hit) begin
                            r_resp_valid <= 1'b1;
                            r_resp_inst  <= w_line_data;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_state    <= IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    if (mem_resp_valid) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IC_IDLE;
                        if (!cancel) begin
                            r_resp_valid <= 1'b1;
                            r_resp_inst  <= mem_resp_data;
                        end
                    end else if (cancel) begin
                        r_state <= IC_DRAIN;
                    end
                end
                // mem_ctrl cannot abort, so wait out the read and keep the fill.
                IC_DRAIN: begin
                    if (mem_resp_valid) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IC_IDLE;
                    end
                end
                default: r_state <= IC_IDLE;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_inst  = r_resp_inst;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_icache : scoreboard bench with a latency-programmable memory      |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_icache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        cancel;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          mreq_count = 0;
    logic        mreq_prev  = 1'b0;
    logic        rdy_q      = 1'b0;
    int          lat        = 2;
    int          mem_cnt    = 0;

    icache #(.LINES(64), .ADDR_W(32)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .cancel         (cancel),
        .resp_valid     (resp_valid),
        .resp_inst      (resp_inst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00000513;
        return {a[15:0], 16'h0093} ^ 32'h00A50000;
    endfunction

    // Memory controller: answers a held mem_req after 'lat' cycles.
    always @(posedge clk_in) begin
        #2;
        if (!rst_in) begin
            mem_resp_valid = 1'b0;
            mem_cnt        = 0;
        end else if (rdy_in) begin
            if (mem_resp_valid) begin
                mem_resp_valid = 1'b0;
                mem_cnt        = 0;
            end else if (mem_req) begin
                if (mem_cnt >= lat) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(mem_addr);
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    always @(posedge clk_in) rdy_q <= rdy_in;

    always @(negedge clk_in) begin
        if (mem_req && !mreq_prev) mreq_count++;
        mreq_prev = mem_req;
    end

    // Scoreboard: each productive resp_valid pulse pops one expected word.
    always @(negedge clk_in) begin
        if (rst_in && rdy_q && resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected resp_inst=%h with no expected response", resp_inst);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (resp_inst !== e) begin
                    errors++;
                    $display("FAIL sb_data got=%h exp=%h", resp_inst, e);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk_in);
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL fetch_ready req_ready=%b exp=1 addr=%h", req_ready, a);
        end
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk_in);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_ready !== 1'b1) && n < 200) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    task automatic wait_mem_resp();
        int n;
        n = 0;
        while (mem_resp_valid !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++;
        if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_valids resp_valid=%b mem_req=%b exp=0/0", resp_valid, mem_req);
        end
        checks++;
        if (resp_inst !== 32'h0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_data resp_inst=%h mem_addr=%h exp=0/0", resp_inst, mem_addr);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_cold_miss();
        int m0;
        lat = 2;
        m0  = mreq_count;
        exp_q.push_back(32'h00000513);
        fetch(32'h100);
        @(negedge clk_in);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL cold_mem_req mem_req=%b mem_addr=%h req_ready=%b exp=1/00000100/0", mem_req, mem_addr, req_ready);
        end
        wait_mem_resp();
        @(negedge clk_in);
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h00000513) begin
            errors++; $display("FAIL cold_resp resp_valid=%b resp_inst=%h exp=1/00000513", resp_valid, resp_inst);
        end
        wait_drain();
        m0 = mreq_count;
        exp_q.push_back(32'h00000513);
        fetch(32'h100);
        @(negedge clk_in);
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h00000513 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL cold_hit resp_valid=%b resp_inst=%h mem_req=%b exp=1/00000513/0", resp_valid, resp_inst, mem_req);
        end
        wait_drain();
        checks++;
        if (mreq_count != m0 || exp_q.size() != 0) begin
            errors++; $display("FAIL cold_hit_nomem mem_reqs=%0d pending=%0d exp=0/0", mreq_count - m0, exp_q.size());
        end
    endtask

    task automatic test_conflict();
        logic [31:0] seq [3];
        int          exp_miss [3];
        int          m0;
        seq      = '{32'h200, 32'h100, 32'h100};
        exp_miss = '{1, 1, 0};
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            m0 = mreq_count;
            exp_q.push_back(mem_word(seq[i]));
            fetch(seq[i]);
            wait_drain();
            checks++;
            if (mreq_count - m0 != exp_miss[i] || exp_q.size() != 0) begin
                errors++;
                $display("FAIL conflict_%0d addr=%h mem_reqs=%0d pending=%0d exp=%0d/0", i, seq[i], mreq_count - m0, exp_q.size(), exp_miss[i]);
            end
        end
    endtask

    task automatic test_cancel_miss();
        int m0;
        lat = 6;
        fetch(32'h300);
        @(negedge clk_in);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL cxl_req_start mem_req=%b exp=1", mem_req); end
        @(negedge clk_in);
        cancel = 1'b1;
        @(posedge clk_in);
        #1 cancel = 1'b0;
        @(negedge clk_in);
        checks++;
        if (mem_req !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL cxl_drain_hold mem_req=%b req_ready=%b exp=1/0", mem_req, req_ready);
        end
        wait_mem_resp();
        checks++;
        if (mem_resp_valid !== 1'b1 || mem_req !== 1'b1) begin
            errors++; $display("FAIL cxl_drain_resp mem_resp_valid=%b mem_req=%b exp=1/1", mem_resp_valid, mem_req);
        end
        @(negedge clk_in);
        checks++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL cxl_drain_done mem_req=%b resp_valid=%b req_ready=%b exp=0/0/1", mem_req, resp_valid, req_ready);
        end
        m0 = mreq_count;
        exp_q.push_back(mem_word(32'h300));
        fetch(32'h300);
        wait_drain();
        checks++;
        if (mreq_count != m0 || exp_q.size() != 0) begin
            errors++; $display("FAIL cxl_refetch_hit mem_reqs=%0d pending=%0d exp=0/0", mreq_count - m0, exp_q.size());
        end
    endtask

    task automatic test_cancel_coincident();
        int m0;
        lat = 3;
        fetch(32'h0A0);
        wait_mem_resp();
        cancel = 1'b1;
        @(negedge clk_in);
        cancel = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL coinc_state resp_valid=%b req_ready=%b mem_req=%b exp=0/1/0", resp_valid, req_ready, mem_req);
        end
        m0 = mreq_count;
        exp_q.push_back(mem_word(32'h0A0));
        fetch(32'h0A0);
        @(negedge clk_in);
        checks++;
        if (resp_valid !== 1'b1 || mreq_count != m0) begin
            errors++; $display("FAIL coinc_filled resp_valid=%b mem_reqs=%0d exp=1/0", resp_valid, mreq_count - m0);
        end
        wait_drain();
    endtask

    task automatic test_pause();
        logic [31:0] w;
        int          m0;
        w = mem_word(32'h300);
        exp_q.push_back(w);
        fetch(32'h300);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            checks++;
            if (resp_valid !== 1'b1 || resp_inst !== w || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL pause_hit_%0d resp_valid=%b resp_inst=%h req_ready=%b exp=1/%h/0", i, resp_valid, resp_inst, req_ready, w);
            end
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL pause_hit_release resp_valid=%b req_ready=%b exp=0/1", resp_valid, req_ready);
        end
        lat = 4;
        m0  = mreq_count;
        w   = mem_word(32'h3C0);
        exp_q.push_back(w);
        fetch(32'h3C0);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h3C0 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL pause_miss_%0d mem_req=%b mem_addr=%h resp_valid=%b exp=1/000003c0/0", i, mem_req, mem_addr, resp_valid);
            end
        end
        rdy_in = 1'b1;
        wait_mem_resp();
        @(negedge clk_in);
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== w || mreq_count - m0 != 1) begin
            errors++;
            $display("FAIL pause_miss_resp resp_valid=%b resp_inst=%h mem_reqs=%0d exp=1/%h/1", resp_valid, resp_inst, mreq_count - m0, w);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] seq [2];
        int          m0;
        seq = '{32'h0A0, 32'h100};
        lat = 8;
        fetch(32'h500);
        @(negedge clk_in);
        @(negedge clk_in);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rmm_pre mem_req=%b exp=1", mem_req); end
        rst_in = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rmm_async mem_req=%b req_ready=%b mem_addr=%h exp=0/0/0", mem_req, req_ready, mem_addr);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        lat    = 2;
        for (int i = 0; i < 2; i++) begin
            m0 = mreq_count;
            exp_q.push_back(mem_word(seq[i]));
            fetch(seq[i]);
            wait_drain();
            checks++;
            if (mreq_count - m0 != 1 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL rmm_invalid_%0d addr=%h mem_reqs=%0d pending=%0d exp=1/0", i, seq[i], mreq_count - m0, exp_q.size());
            end
        end
    endtask

    task automatic test_io();
        int m0;
        lat = 1;
        for (int i = 0; i < 2; i++) begin
            m0 = mreq_count;
            exp_q.push_back(mem_word(32'h30000));
            fetch(32'h30000);
            wait_drain();
            checks++;
            if (mreq_count - m0 != 1 || exp_q.size() != 0) begin
                errors++; $display("FAIL io_miss_%0d mem_reqs=%0d pending=%0d exp=1/0", i, mreq_count - m0, exp_q.size());
            end
        end
        m0 = mreq_count;
        exp_q.push_back(32'h00000513);
        fetch(32'h100);
        wait_drain();
        checks++;
        if (mreq_count != m0 || exp_q.size() != 0) begin
            errors++; $display("FAIL io_no_alloc mem_reqs=%0d pending=%0d exp=0/0", mreq_count - m0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int m0;
        m0 = mreq_count;
        exp_q.push_back(32'h00000513);
        exp_q.push_back(mem_word(32'h0A0));
        @(negedge clk_in);
        req_valid = 1'b1;
        req_addr  = 32'h100;
        @(posedge clk_in);
        #1 req_addr = 32'h0A0;
        @(negedge clk_in);
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first resp_valid=%b req_ready=%b exp=1/1", resp_valid, req_ready);
        end
        @(posedge clk_in);
        #1 req_valid = 1'b0;
        @(negedge clk_in);
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== mem_word(32'h0A0)) begin
            errors++; $display("FAIL b2b_second resp_valid=%b resp_inst=%h exp=1/%h", resp_valid, resp_inst, mem_word(32'h0A0));
        end
        wait_drain();
        checks++;
        if (mreq_count != m0 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_nomem mem_reqs=%0d pending=%0d exp=0/0", mreq_count - m0, exp_q.size());
        end
    endtask

    initial begin
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        cancel    = 1'b0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_cancel_miss();
        test_cancel_coincident();
        test_pause();
        test_reset_mid_miss();
        test_io();
        test_back_to_back();
        repeat (2) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout sim_time=%0t limit=500000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
